// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions used by the fetch stage: FSM state type and bubble word.
package fetch_unit_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [15:0] REDIRECT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls; flush wins over load.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic [31:0]     fetch_instr,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr,
    output logic            valid
);

    // Bubble on reset or flush, capture fetched word on load, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= fetch_pc;
            instr <= fetch_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, RUN/HALTED control, redirect bookkeeping and IF/ID.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [31:0]     br_pc,
    input  logic            halt,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            halted,
    output logic            misalign,
    output logic [15:0]     redirect_cnt
);

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            run;
    logic            take_redirect;
    logic            advance;
    logic            flush_ifid;

    // Target bits above the PC width are dropped by design.
    logic unused_br_hi;
    assign unused_br_hi = ^br_pc[31:PC_W];

    assign run           = (state == RUN);
    // Halt outranks both redirect and stall.
    assign take_redirect = run & pc_sel & ~halt;
    assign advance       = run & ~halt & ~pc_sel & ~stall;
    // Once halted the IF/ID register is kept as a bubble forever.
    assign flush_ifid    = ~run | halt | pc_sel;

    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    // Next PC: word-aligned redirect target, sequential step, or hold.
    always_comb begin
        pc_next = pc;
        if (take_redirect) begin
            pc_next = {br_pc[PC_W-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc + PC_W'(4);
        end
    end

    // PC, FSM state and redirect bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= '0;
            state        <= RUN;
            misalign     <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (run && halt) begin
                state <= HALTED;
            end
            if (take_redirect && (br_pc[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
            if (take_redirect && (redirect_cnt != REDIRECT_CNT_MAX)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end

    if_id_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (advance),
        .flush       (flush_ifid),
        .fetch_pc    (pc),
        .fetch_instr (imem_rdata),
        .pc          (if_id_pc),
        .instr       (if_id_instr),
        .valid       (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a
// behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int unsigned PC_W   = 9;
    localparam int unsigned PC_MOD = 1 << PC_W;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            pc_sel;
    logic [31:0]     br_pc;
    logic            halt;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [PC_W-1:0] if_id_pc;
    logic [31:0]     if_id_instr;
    logic            if_id_valid;
    logic            halted;
    logic            misalign;
    logic [15:0]     redirect_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    int unsigned m_pc;
    bit          m_halted;
    int unsigned m_if_pc;
    logic [31:0] m_if_instr;
    bit          m_if_valid;
    bit          m_mis;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    // Instruction memory contents: an arbitrary address-dependent pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem_word(32'(imem_addr));

    fetch_unit #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .br_pc        (br_pc),
        .halt         (halt),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "/imem_addr"}, 32'(imem_addr), m_pc);
        check({tag, "/if_id_pc"}, 32'(if_id_pc), m_if_pc);
        check({tag, "/if_id_instr"}, if_id_instr, m_if_instr);
        check({tag, "/if_id_valid"}, 32'(if_id_valid), 32'(m_if_valid));
        check({tag, "/halted"}, 32'(halted), 32'(m_halted));
        check({tag, "/misalign"}, 32'(misalign), 32'(m_mis));
        check({tag, "/redirect_cnt"}, 32'(redirect_cnt), m_cnt);
    endtask

    task automatic model_reset();
        m_pc       = 0;
        m_halted   = 0;
        m_if_pc    = 0;
        m_if_instr = NOP;
        m_if_valid = 0;
        m_mis      = 0;
        m_cnt      = 0;
    endtask

    task automatic model_bubble();
        m_if_pc    = 0;
        m_if_instr = NOP;
        m_if_valid = 0;
    endtask

    // One clock of the fetch rules, evaluated from the inputs present before the edge.
    task automatic model_step();
        if (m_halted) begin
            model_bubble();
        end else if (halt) begin
            m_halted = 1;
            model_bubble();
        end else if (pc_sel) begin
            m_pc = ((br_pc % PC_MOD) / 4) * 4;
            if ((br_pc % 4) != 0) m_mis = 1;
            if (m_cnt < 32'hFFFF) m_cnt++;
            model_bubble();
        end else if (!stall) begin
            m_if_pc    = m_pc;
            m_if_instr = mem_word(m_pc);
            m_if_valid = 1;
            m_pc       = (m_pc + 4) % PC_MOD;
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic [31:0] b, input logic h);
        stall  = s;
        pc_sel = p;
        br_pc  = b;
        halt   = h;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check_state(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        apply_reset("reset");

        // Sequential fetch from address 0.
        check("seq/addr0", 32'(imem_addr), 32'h0);
        cycle();
        check("seq/addr4", 32'(imem_addr), 32'h4);
        check("seq/ifid_pc0", 32'(if_id_pc), 32'h0);
        check("seq/valid0", 32'(if_id_valid), 32'h1);
        cycle();
        check("seq/addr8", 32'(imem_addr), 32'h8);
        check("seq/ifid_pc4", 32'(if_id_pc), 32'h4);
        check_state("seq");
        cycle();
        cycle();
        check("seq/addr10", 32'(imem_addr), 32'h10);

        // Redirect wins over stall.
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        cycle();
        check("redir/pc", 32'(imem_addr), 32'h40);
        check("redir/valid", 32'(if_id_valid), 32'h0);
        check("redir/instr", if_id_instr, NOP);
        check("redir/cnt", 32'(redirect_cnt), 32'h1);
        check_state("redir");

        // Stall holds everything.
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        cycle();
        cycle();
        check_state("stall");

        // Wrap at the top of the PC space, then truncated misaligned redirect.
        drive(1'b0, 1'b1, 32'h1FC, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        cycle();
        check("wrap/pc", 32'(imem_addr), 32'h0);
        check("wrap/ifid_pc", 32'(if_id_pc), 32'h1FC);
        drive(1'b0, 1'b1, 32'h0000_0A06, 1'b0);
        cycle();
        check("trunc/pc", 32'(imem_addr), 32'h4);
        check("trunc/misalign", 32'(misalign), 32'h1);
        check_state("trunc");

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        cycle();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("areset/pc", 32'(imem_addr), 32'h0);
        check_state("areset");
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        cycle();
        check("areset/first_pc", 32'(if_id_pc), 32'h0);
        check("areset/first_valid", 32'(if_id_valid), 32'h1);
        check_state("areset_run");

        // Random traffic, halt held low.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom, 1'b0);
            cycle();
            check_state("rand");
        end

        // Counter saturation.
        apply_reset("sat_reset");
        drive(1'b0, 1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 65534; i++) cycle();
        check("sat/fffe", 32'(redirect_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("sat/ffff", 32'(redirect_cnt), 32'hFFFF);
        end
        check_state("sat");

        // Halt beats a simultaneous redirect; afterwards everything is ignored.
        apply_reset("halt_reset");
        drive(1'b0, 1'b1, 32'h20, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 32'h80, 1'b1);
        cycle();
        check("halt/pc", 32'(imem_addr), 32'h20);
        check("halt/halted", 32'(halted), 32'h1);
        check("halt/cnt", 32'(redirect_cnt), 32'h1);
        check_state("halt");
        for (int i = 0; i < 6; i++) begin
            drive($urandom_range(0, 1) == 1, (i % 2) == 0, $urandom, $urandom_range(0, 1) == 1);
            cycle();
            check_state("halted_ignore");
        end
        check("halt/cnt_final", 32'(redirect_cnt), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
